// File: rtl/frame_update_scheduler.sv
// ============================================================================
// Module  : frame_update_scheduler
// Brief   : Issues one frame tick per vertical-blanking entry and grants each
//           game-logic client a single req/ack update slot in index order.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_update_scheduler #(
    parameter int V_ACTIVE    = 480,
    parameter int NUM_CLIENTS = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [9:0]             i_vpos,
    input  logic                   i_enable,
    input  logic                   i_pause,
    input  logic                   i_clear,
    output logic [NUM_CLIENTS-1:0] o_req,
    input  logic [NUM_CLIENTS-1:0] i_ack,
    output logic                   o_frame_tick,
    output logic [7:0]             o_frame_cnt,
    output logic                   o_busy,
    output logic [NUM_CLIENTS-1:0] o_timeout_err,
    output logic                   o_overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [9:0]             c_V_ACTIVE  = 10'(V_ACTIVE);
    localparam logic [7:0]             c_WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [NUM_CLIENTS-1:0] c_FIRST     = NUM_CLIENTS'(1);

    state_t                   r_state;
    logic                     r_vblank_q;
    logic [NUM_CLIENTS-1:0]   r_req;
    logic                     r_busy;
    logic                     r_tick;
    logic [7:0]               r_frame_cnt;
    logic [7:0]               r_wait;
    logic [NUM_CLIENTS-1:0]   r_to_err;
    logic                     r_overrun;

    state_t                   w_state_nxt;
    logic [NUM_CLIENTS-1:0]   w_req_nxt;
    logic                     w_busy_nxt;
    logic                     w_tick_nxt;
    logic [7:0]               w_cnt_nxt;
    logic [7:0]               w_wait_nxt;
    logic [NUM_CLIENTS-1:0]   w_to_set;

    logic w_in_vblank;
    logic w_vb_rise;
    logic w_vb_fall;
    logic w_ack;
    logic w_timeout;
    logic w_ov_set;

    assign w_in_vblank = (i_vpos >= c_V_ACTIVE);
    assign w_vb_rise   = w_in_vblank & ~r_vblank_q;
    assign w_vb_fall   = ~w_in_vblank & r_vblank_q;

    // r_req is one-hot, so masking selects only the served client's ack
    assign w_ack       = |(i_ack & r_req);
    assign w_timeout   = (r_wait == c_WAIT_LAST);
    assign w_ov_set    = (w_vb_rise | w_vb_fall) & r_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_busy_nxt  = r_busy;
        w_tick_nxt  = 1'b0;
        w_cnt_nxt   = r_frame_cnt;
        w_wait_nxt  = r_wait;
        w_to_set    = '0;

        case (r_state)
            S_IDLE: begin
                if (w_vb_rise && i_enable && !i_pause) begin
                    w_tick_nxt  = 1'b1;
                    w_cnt_nxt   = r_frame_cnt + 8'd1;
                    w_busy_nxt  = 1'b1;
                    w_req_nxt   = c_FIRST;
                    w_wait_nxt  = 8'd0;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_ack || w_timeout) begin
                    // an ack on the last allowed cycle takes priority over timeout
                    if (!w_ack) begin
                        w_to_set = r_req;
                    end
                    w_wait_nxt = 8'd0;
                    if (r_req[NUM_CLIENTS-1]) begin
                        w_req_nxt   = '0;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_req_nxt = r_req << 1;
                    end
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_vblank_q  <= 1'b0;
            r_req       <= '0;
            r_busy      <= 1'b0;
            r_tick      <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_wait      <= 8'd0;
            r_to_err    <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_vblank_q  <= w_in_vblank;
            r_req       <= w_req_nxt;
            r_busy      <= w_busy_nxt;
            r_tick      <= w_tick_nxt;
            r_frame_cnt <= w_cnt_nxt;
            r_wait      <= w_wait_nxt;
            // a set event in the same cycle as i_clear keeps the flag high
            r_to_err    <= (r_to_err & ~{NUM_CLIENTS{i_clear}}) | w_to_set;
            r_overrun   <= (r_overrun & ~i_clear) | w_ov_set;
        end
    end

    assign o_req         = r_req;
    assign o_busy        = r_busy;
    assign o_frame_tick  = r_tick;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_timeout_err = r_to_err;
    assign o_overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_frame_update_scheduler.sv
// ============================================================================
// Module  : tb_frame_update_scheduler
// Brief   : Directed bench for frame_update_scheduler (TIMEOUT=8, 4 clients).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_update_scheduler;

    localparam int c_N  = 4;
    localparam int c_TO = 8;

    logic           clk;
    logic           rst_n;
    logic [9:0]     i_vpos;
    logic           i_enable;
    logic           i_pause;
    logic           i_clear;
    logic [c_N-1:0] o_req;
    logic [c_N-1:0] i_ack;
    logic           o_frame_tick;
    logic [7:0]     o_frame_cnt;
    logic           o_busy;
    logic [c_N-1:0] o_timeout_err;
    logic           o_overrun;

    int n_checks = 0;
    int n_errors = 0;

    // Client model: client k acks during the (dly[k]+1)-th cycle its req is seen high;
    // dly[k] < 0 means never. force_ack bits are ORed in unconditionally.
    int             hc [c_N];
    int             dly[c_N];
    logic [c_N-1:0] ack_r;
    logic [c_N-1:0] force_ack;

    assign i_ack = ack_r | force_ack;

    frame_update_scheduler #(
        .V_ACTIVE    (480),
        .NUM_CLIENTS (c_N),
        .TIMEOUT     (c_TO)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_vpos        (i_vpos),
        .i_enable      (i_enable),
        .i_pause       (i_pause),
        .i_clear       (i_clear),
        .o_req         (o_req),
        .i_ack         (i_ack),
        .o_frame_tick  (o_frame_tick),
        .o_frame_cnt   (o_frame_cnt),
        .o_busy        (o_busy),
        .o_timeout_err (o_timeout_err),
        .o_overrun     (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int k = 0; k < c_N; k++) hc[k] = 0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < c_N; k++) begin
            int n;
            n = o_req[k] ? hc[k] + 1 : 0;
            hc[k]    <= n;
            ack_r[k] <= o_req[k] && (dly[k] >= 0) && (n == dly[k] + 1);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    endtask

    // Leave vblank, re-enter it; returns at the first cycle after the rise is registered.
    task automatic frame_start();
        i_vpos = 10'd0;
        cyc(2);
        i_vpos = 10'd480;
        cyc(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        i_vpos    = 10'd479;
        i_enable  = 1'b1;
        i_pause   = 1'b0;
        i_clear   = 1'b0;
        force_ack = '0;
        ack_r     = '0;
        set_dly(3, 3, 3, 3);

        // reset state
        cyc(3);
        check("rst_req",   32'(o_req), 32'h0);
        check("rst_tick",  32'(o_frame_tick), 32'h0);
        check("rst_cnt",   32'(o_frame_cnt), 32'h0);
        check("rst_busy",  32'(o_busy), 32'h0);
        check("rst_flags", {27'd0, o_overrun, o_timeout_err}, 32'h0);
        rst_n = 1'b1;
        cyc(2);
        check("idle_tick", 32'(o_frame_tick), 32'h0);

        // nominal: 479 -> 480, each client acks on its 4th req cycle
        i_vpos = 10'd480;
        cyc(1);
        check("nom_tick",  32'(o_frame_tick), 32'h1);
        check("nom_cnt",   32'(o_frame_cnt), 32'h1);
        check("nom_req0",  32'(o_req), 32'h1);
        check("nom_busy",  32'(o_busy), 32'h1);
        cyc(1);
        check("nom_tick1", 32'(o_frame_tick), 32'h0);
        cyc(2);
        check("nom_req0b", 32'(o_req), 32'h1);
        cyc(1);
        check("nom_req1",  32'(o_req), 32'h2);
        cyc(4);
        check("nom_req2",  32'(o_req), 32'h4);
        cyc(4);
        check("nom_req3",  32'(o_req), 32'h8);
        cyc(3);
        check("nom_busy3", 32'(o_busy), 32'h1);
        cyc(1);
        check("nom_end",   32'(o_req), 32'h0);
        check("nom_idle",  32'(o_busy), 32'h0);
        check("nom_flags", {27'd0, o_overrun, o_timeout_err}, 32'h0);
        cyc(2);

        // timeout: client 1 silent, its req stays up for exactly 8 cycles
        set_dly(0, -1, 0, 0);
        frame_start();
        check("to_req0", 32'(o_req), 32'h1);
        cyc(8);
        check("to_req1", 32'(o_req), 32'h2);
        check("to_err0", 32'(o_timeout_err), 32'h0);
        cyc(1);
        check("to_req2", 32'(o_req), 32'h4);
        check("to_err1", 32'(o_timeout_err), 32'h2);
        cyc(2);
        check("to_end",    32'(o_busy), 32'h0);
        check("to_sticky", 32'(o_timeout_err), 32'h2);
        check("to_cnt",    32'(o_frame_cnt), 32'h2);
        i_clear = 1'b1;
        cyc(1);
        i_clear = 1'b0;
        check("to_clear", 32'(o_timeout_err), 32'h0);
        cyc(2);

        // pause / disable at vblank entry
        set_dly(0, 0, 0, 0);
        i_pause = 1'b1;
        frame_start();
        check("pause_tick", 32'(o_frame_tick), 32'h0);
        check("pause_cnt",  32'(o_frame_cnt), 32'h2);
        check("pause_req",  32'(o_req), 32'h0);
        i_pause  = 1'b0;
        i_enable = 1'b0;
        frame_start();
        check("dis_tick", 32'(o_frame_tick), 32'h0);
        check("dis_cnt",  32'(o_frame_cnt), 32'h2);
        i_enable = 1'b1;
        frame_start();
        check("midp_tick", 32'(o_frame_tick), 32'h1);
        check("midp_cnt",  32'(o_frame_cnt), 32'h3);
        i_pause = 1'b1;
        cyc(2);
        check("midp_req2", 32'(o_req), 32'h4);
        cyc(2);
        check("midp_end",  32'(o_busy), 32'h0);
        i_pause = 1'b0;
        cyc(2);

        // overrun: vblank ends mid-sequence (with a coincident clear), then re-enters
        set_dly(3, 3, 3, 3);
        frame_start();
        cyc(2);
        i_vpos  = 10'd0;
        i_clear = 1'b1;
        cyc(1);
        i_clear = 1'b0;
        check("ov_set",   32'(o_overrun), 32'h1);
        cyc(1);
        check("ov_req1",  32'(o_req), 32'h2);
        cyc(1);
        i_vpos = 10'd480;
        cyc(1);
        check("ov_notick", 32'(o_frame_tick), 32'h0);
        check("ov_cnt",    32'(o_frame_cnt), 32'h4);
        cyc(6);
        check("ov_req3",  32'(o_req), 32'h8);
        cyc(4);
        check("ov_done",  32'(o_busy), 32'h0);
        check("ov_sticky", 32'(o_overrun), 32'h1);
        i_clear = 1'b1;
        cyc(1);
        i_clear = 1'b0;
        check("ov_clear", 32'(o_overrun), 32'h0);
        cyc(2);

        // stray and held acks; client 3 acks on its final allowed cycle
        set_dly(3, 0, 0, 7);
        force_ack = 4'b1100;
        frame_start();
        cyc(1);
        check("stray_req0", 32'(o_req), 32'h1);
        cyc(2);
        force_ack = 4'b0100;
        cyc(1);
        check("held_req1", 32'(o_req), 32'h2);
        cyc(1);
        check("held_req2", 32'(o_req), 32'h4);
        cyc(1);
        check("held_req3", 32'(o_req), 32'h8);
        cyc(7);
        check("last_req3", 32'(o_req), 32'h8);
        cyc(1);
        check("last_end",  32'(o_req), 32'h0);
        check("last_err",  32'(o_timeout_err), 32'h0);
        check("last_cnt",  32'(o_frame_cnt), 32'h5);
        force_ack = '0;
        cyc(2);

        // asynchronous reset mid-sequence, then restart from vblank and wrap the counter
        set_dly(3, 3, 3, 3);
        frame_start();
        cyc(8);
        check("mid_req2", 32'(o_req), 32'h4);
        rst_n = 1'b0;
        #1;
        check("arst_req",  32'(o_req), 32'h0);
        check("arst_busy", 32'(o_busy), 32'h0);
        check("arst_cnt",  32'(o_frame_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        check("rel_tick", 32'(o_frame_tick), 32'h1);
        check("rel_cnt",  32'(o_frame_cnt), 32'h1);
        check("rel_req",  32'(o_req), 32'h1);
        cyc(18);
        set_dly(0, 0, 0, 0);
        for (int f = 0; f < 254; f++) begin
            frame_start();
            cyc(5);
        end
        check("wrap_pre", 32'(o_frame_cnt), 32'hff);
        frame_start();
        check("wrap_tick", 32'(o_frame_tick), 32'h1);
        check("wrap_cnt",  32'(o_frame_cnt), 32'h0);
        cyc(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frame_update_scheduler.md
Name: frame_update_scheduler

Overview:
Sequences per-frame game-state updates against the VGA raster produced by the graphics pipeline.
- Detects entry into vertical blanking from the raster position and issues one frame tick.
- Grants each game-logic client (player, obstacle, score, collision…) a single update slot in fixed index order, using req/ack handshakes.
- Clients therefore never change sprite state while the color compare stage is sampling active video.
- Flags clients that time out and sequences that spill past vblank.

Parameters:
V_ACTIVE, 480, number of visible lines; vblank region is i_vpos >= V_ACTIVE
NUM_CLIENTS, 4, number of update clients, legal range 1..8
TIMEOUT, 255, max cycles a request stays high without ack, legal range 2..255

Ports:
clk  input  1  system clock (pixel clock)
rst_n  input  1  asynchronous active-low reset
i_vpos  input  10  current raster line from graphics_top
i_enable  input  1  scheduler enable; sampled only at vblank entry
i_pause  input  1  game paused; sampled only at vblank entry
i_clear  input  1  synchronous clear of sticky error flags
o_req  output  NUM_CLIENTS  one-hot update request, bit k = client k
i_ack  input  NUM_CLIENTS  update done, bit k from client k
o_frame_tick  output  1  one-cycle pulse at start of each scheduled frame
o_frame_cnt  output  8  count of scheduled frames, wraps 255->0
o_busy  output  1  sequence in progress
o_timeout_err  output  NUM_CLIENTS  sticky per-client timeout flags
o_overrun  output  1  sticky: sequence still busy when active video resumed, or vblank re-entered while busy

Behaviour:
- Reset (rst_n low, async): all outputs 0, FSM = IDLE, in_vblank_q = 0, wait counter = 0, client index = 0.
- in_vblank = (i_vpos >= V_ACTIVE), combinational. in_vblank_q is its registered copy.
- vb_rise = in_vblank & ~in_vblank_q. vb_fall = ~in_vblank & in_vblank_q.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On vb_rise with i_enable=1 and i_pause=0: next cycle o_frame_tick=1 (exactly one cycle), o_frame_cnt+1, o_busy=1, o_req=one-hot bit 0, wait counter=0, state=REQ.
  - On vb_rise with i_enable=0 or i_pause=1: no tick, counter unchanged, stay IDLE.
- REQ, serving client k:
  - o_req[k]=1 and all other bits 0.
  - If i_ack[k]=1 in cycle M and k<NUM_CLIENTS-1: in M+1, o_req[k]=0, o_req[k+1]=1, wait counter=0. There is no gap cycle.
  - If i_ack[k]=1 in cycle M and k=NUM_CLIENTS-1: in M+1, o_req=0, o_busy=0, state=DONE.
  - Wait counter increments each REQ cycle without ack.
  - Timeout: o_req[k] is high for TIMEOUT cycles with no ack. In the following cycle o_timeout_err[k] is set and the FSM advances exactly as for an ack.
  - Ack on the final allowed cycle counts as an ack, not a timeout.
- DONE: one cycle, then IDLE. This guarantees o_busy is low for at least one cycle between sequences.
- i_ack bits for non-requested clients are ignored. An ack held high is only consumed once per request.
- Overrun: o_overrun is set on vb_fall while o_busy=1, or on vb_rise while o_busy=1.
  - The sequence is never aborted; it completes normally.
  - A vb_rise during busy does not start a new sequence and does not tick.
- i_enable / i_pause changes mid-sequence have no effect until the next vb_rise.
- i_clear: o_timeout_err and o_overrun go to 0 next cycle. A set event in the same cycle as i_clear wins (flag stays 1).
- o_frame_cnt wraps 255 -> 0 silently.
- Reset mid-sequence: everything returns to reset values immediately. After release, a new sequence needs a fresh vb_rise. in_vblank_q resets to 0, so releasing reset while i_vpos>=V_ACTIVE produces a vb_rise one cycle later.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Nominal, TIMEOUT=8, NUM_CLIENTS=4, enable=1: i_vpos steps 479->480. Next cycle tick=1, frame_cnt 0->1, o_req=0001. Each client acks 3 cycles after its req rises. o_req walks 0010, 0100, 1000, then 0000; o_busy low 1 cycle after ack[3]; no error flags.
- Timeout: client 1 never acks. o_req=0010 for exactly 8 cycles, then o_timeout_err=0010 and o_req=0100. i_clear=1 afterwards returns o_timeout_err to 0000.
- Pause/disable: i_pause=1 at vblank entry gives no tick, frame_cnt unchanged, o_req stays 0. i_enable=0 gives the same. Toggling i_pause mid-sequence leaves the running sequence unaffected.
- Overrun: acks delayed so the sequence is still busy when i_vpos wraps to 0. o_overrun=1 and the sequence still completes all 4 clients.
- Stray/held acks: ack[2] held high from the start gives client 2 exactly one one-cycle-wide slot. Acks on non-requested bits never advance the FSM.
- Reset/wrap: assert rst_n=0 while o_req=0100; all outputs clear asynchronously. Run 256 frames; o_frame_cnt reads 0 and tick still pulses.
